stepper_move_engine: RTL and testbench

Parametrised move-to-step engine for the cube-solving robot. It accepts one face move per handshake and selects one of `NUM_CH` stepper drivers, which share a single step line and a single direction line. It generates a paced step train for a quarter or half turn, then holds the driver enabled for a settle window before reporting done. It sits between the move-sequence player and the stepper driver boards.

---
 rtl/stepper_move_engine_if.sv | 28 ++
 rtl/stepper_move_engine.sv | 195 +++++++++++++++++++
 tb/tb_stepper_move_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/stepper_move_engine_if.sv
// Move-request handshake, status and shared stepper-driver pins for stepper_move_engine.
interface stepper_move_engine_if #(
    parameter int NUM_CH = 6
);
    logic              disable_steppers;
    logic [3:0]        next_move;
    logic [1:0]        next_turns;
    logic              move_start;
    logic              move_ready;
    logic              move_done;
    logic              move_aborted;
    logic              invalid_move;
    logic              dir_pin;
    logic              step_pin;
    logic [NUM_CH-1:0] en_pins;

    modport master (
        output disable_steppers, next_move, next_turns, move_start,
        input  move_ready, move_done, move_aborted, invalid_move,
        input  dir_pin, step_pin, en_pins
    );

    modport slave (
        input  disable_steppers, next_move, next_turns, move_start,
        output move_ready, move_done, move_aborted, invalid_move,
        output dir_pin, step_pin, en_pins
    );
endinterface

// File: rtl/stepper_move_engine.sv
// Face move to paced step train on one of NUM_CH shared-step/dir stepper drivers.
// Optional macro STEPPER_RAMP_EN adds a symmetric accelerate/decelerate period profile.
module stepper_move_engine #(
    parameter int NUM_CH            = 6,
    parameter int QUARTER_STEPS     = 50,
    parameter int STEP_PERIOD       = 125000,
    parameter int DIR_SETUP         = 250,
    parameter int SETTLE_CYCLES     = 2500000,
    parameter int RAMP_START_PERIOD = 250000,
    parameter int RAMP_DEC          = 12500
) (
    input  logic                  clock,
    input  logic                  reset,
    stepper_move_engine_if.slave  mv
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STEP_HI = 3'd2;
    localparam logic [2:0] ST_STEP_LO = 3'd3;
    localparam logic [2:0] ST_SETTLE  = 3'd4;

    localparam logic [31:0] STEP_P   = 32'(STEP_PERIOD);
    localparam logic [31:0] SETUP_C  = 32'(DIR_SETUP);
    localparam logic [31:0] SETTLE_C = 32'(SETTLE_CYCLES);
    localparam logic [15:0] QSTEPS   = 16'(QUARTER_STEPS);

    if (STEP_PERIOD < 2 || DIR_SETUP < 1 || QUARTER_STEPS < 1 || SETTLE_CYCLES < 0 ||
        NUM_CH < 1 || RAMP_START_PERIOD < 0 || RAMP_DEC < 0) begin : g_param_check
        $error("stepper_move_engine: illegal parameter value");
    end

    logic [2:0]      state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [15:0]     steps_q, steps_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            dir_q, dir_d;
    logic            aborted_q, aborted_d;
    logic            invalid_q, invalid_d;
    logic [31:0]     per_cur, per_next;

    function automatic logic [31:0] hi_len(input logic [31:0] p);
        return p >> 1;
    endfunction

    function automatic logic [31:0] lo_len(input logic [31:0] p);
        return p - (p >> 1);
    endfunction

    logic [2:0] face;
    logic       req_valid;
    assign face      = mv.next_move[3:1];
    assign req_valid = (face != 3'd0) && (32'(face) <= 32'(NUM_CH)) &&
                       ((mv.next_turns == 2'd1) || (mv.next_turns == 2'd2));

`ifdef STEPPER_RAMP_EN
    logic [15:0] k_q, k_d;
    logic [15:0] total_q, total_d;

    // Distance from the nearer end of the move sets how far the period has ramped down.
    function automatic logic [31:0] ramp_period(input logic [15:0] k, input logic [15:0] n);
        logic [15:0] mirror;
        logic [15:0] d;
        logic [47:0] dec;
        mirror = n - 16'd1 - k;
        d      = (k < mirror) ? k : mirror;
        dec    = 48'(d) * 48'(RAMP_DEC);
        if (48'(RAMP_START_PERIOD) > dec + 48'(STEP_PERIOD))
            return 32'(48'(RAMP_START_PERIOD) - dec);
        else
            return STEP_P;
    endfunction

    assign per_cur  = ramp_period(k_q, total_q);
    assign per_next = ramp_period(k_q + 16'd1, total_q);
`else
    assign per_cur  = STEP_P;
    assign per_next = STEP_P;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        steps_d   = steps_q;
        ch_d      = ch_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;
        invalid_d = 1'b0;
`ifdef STEPPER_RAMP_EN
        k_d       = k_q;
        total_d   = total_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mv.move_start && !mv.disable_steppers) begin
                    if (req_valid) begin
                        state_d   = ST_SETUP;
                        cnt_d     = SETUP_C - 32'd1;
                        steps_d   = (mv.next_turns == 2'd2) ? (QSTEPS << 1) : QSTEPS;
                        ch_d      = CH_W'(face - 3'd1);
                        dir_d     = !mv.next_move[0];
                        aborted_d = 1'b0;
`ifdef STEPPER_RAMP_EN
                        k_d       = 16'd0;
                        total_d   = (mv.next_turns == 2'd2) ? (QSTEPS << 1) : QSTEPS;
`endif
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_STEP_HI;
                    cnt_d   = hi_len(per_cur) - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_STEP_HI: begin
                if (cnt_q == 32'd0) begin
                    state_d = ST_STEP_LO;
                    cnt_d   = lo_len(per_cur) - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_STEP_LO: begin
                if (cnt_q == 32'd0) begin
                    steps_d = steps_q - 16'd1;
                    if (steps_q == 16'd1) begin
                        state_d = (SETTLE_C == 32'd0) ? ST_IDLE : ST_SETTLE;
                        cnt_d   = SETTLE_C - 32'd1;
                    end else begin
                        state_d = ST_STEP_HI;
                        cnt_d   = hi_len(per_next) - 32'd1;
`ifdef STEPPER_RAMP_EN
                        k_d     = k_q + 16'd1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 32'd0) state_d = ST_IDLE;
                else                cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // An abort skips the settle window entirely.
        if (state_q != ST_IDLE && mv.disable_steppers) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 32'd0;
            steps_q   <= 16'd0;
            ch_q      <= '0;
            dir_q     <= 1'b0;
            aborted_q <= 1'b0;
            invalid_q <= 1'b0;
`ifdef STEPPER_RAMP_EN
            k_q       <= 16'd0;
            total_q   <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            ch_q      <= ch_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
            invalid_q <= invalid_d;
`ifdef STEPPER_RAMP_EN
            k_q       <= k_d;
            total_q   <= total_d;
`endif
        end
    end

    assign mv.move_ready   = (state_q == ST_IDLE);
    assign mv.move_done    = (state_q == ST_IDLE);
    assign mv.move_aborted = aborted_q;
    assign mv.invalid_move = invalid_q;
    assign mv.dir_pin      = dir_q;
    assign mv.step_pin     = (state_q == ST_STEP_HI);
    assign mv.en_pins      = (state_q == ST_IDLE) ? '1 : ~(NUM_CH'(1) << ch_q);
endmodule

// File: tb/tb_stepper_move_engine.sv
// Directed bench for stepper_move_engine with short timing parameters.
module tb_stepper_move_engine;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   pq[6];
    int   ph[6];

    stepper_move_engine_if #(.NUM_CH(6)) bus ();

    stepper_move_engine #(
        .NUM_CH(6), .QUARTER_STEPS(3), .STEP_PERIOD(4), .DIR_SETUP(2),
        .SETTLE_CYCLES(5), .RAMP_START_PERIOD(8), .RAMP_DEC(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mv(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step pulse k starts 3 cycles after the request and is high for per[k]/2 cycles.
    function automatic logic exp_step(input int c, input int per[6], input int n);
        int t;
        t = 3;
        for (int k = 0; k < n; k++) begin
            if (c >= t && c < t + per[k] / 2) return 1'b1;
            t = t + per[k];
        end
        return 1'b0;
    endfunction

    function automatic int move_len(input int per[6], input int n);
        int t;
        t = 3;
        for (int k = 0; k < n; k++) t = t + per[k];
        return t + 5;
    endfunction

    task automatic run_move(input string tag, input logic [3:0] code, input logic [1:0] tn,
                            input logic [5:0] exp_en, input logic exp_dir,
                            input int per[6], input int n);
        int len;
        len = move_len(per, n);
        bus.next_move  = code;
        bus.next_turns = tn;
        bus.move_start = 1'b1;
        for (int c = 1; c <= len; c++) begin
            tick();
            bus.move_start = 1'b0;
            chk({tag, " step"}, 32'(bus.step_pin), 32'(exp_step(c, per, n)));
            chk({tag, " en"}, 32'(bus.en_pins), 32'((c < len) ? exp_en : 6'h3f));
            chk({tag, " done"}, 32'(bus.move_done), 32'(c == len));
            if (c == 1) chk({tag, " dir"}, 32'(bus.dir_pin), 32'(exp_dir));
        end
    endtask

    logic [3:0] inv_mv[5];
    logic [1:0] inv_tn[5];

    initial begin
        checks = 0;
        errors = 0;
`ifdef STEPPER_RAMP_EN
        pq = '{8, 6, 8, 0, 0, 0};
        ph = '{8, 6, 4, 4, 6, 8};
`else
        pq = '{4, 4, 4, 0, 0, 0};
        ph = '{4, 4, 4, 4, 4, 4};
`endif
        inv_mv = '{4'd14, 4'd2, 4'd2, 4'd1, 4'd15};
        inv_tn = '{2'd1, 2'd0, 2'd3, 2'd1, 2'd2};

        reset                = 1'b1;
        bus.disable_steppers = 1'b0;
        bus.next_move        = 4'd0;
        bus.next_turns       = 2'd0;
        bus.move_start       = 1'b0;
        tick();
        tick();
        chk("rst en", 32'(bus.en_pins), 32'(6'h3f));
        chk("rst step", 32'(bus.step_pin), 32'd0);
        chk("rst dir", 32'(bus.dir_pin), 32'd0);
        chk("rst ready", 32'(bus.move_ready), 32'd1);
        chk("rst done", 32'(bus.move_done), 32'd1);
        chk("rst aborted", 32'(bus.move_aborted), 32'd0);
        chk("rst invalid", 32'(bus.invalid_move), 32'd0);
        reset = 1'b0;
        tick();

        run_move("quarter R", 4'd2, 2'd1, 6'b111110, 1'b1, pq, 3);
        run_move("half Di", 4'd13, 2'd2, 6'b011111, 1'b0, ph, 6);

        for (int i = 0; i < 5; i++) begin
            bus.next_move  = inv_mv[i];
            bus.next_turns = inv_tn[i];
            bus.move_start = 1'b1;
            tick();
            bus.move_start = 1'b0;
            chk("invalid pulse", 32'(bus.invalid_move), 32'd1);
            chk("invalid en", 32'(bus.en_pins), 32'(6'h3f));
            chk("invalid done", 32'(bus.move_done), 32'd1);
            tick();
            chk("invalid one-shot", 32'(bus.invalid_move), 32'd0);
            chk("invalid en after", 32'(bus.en_pins), 32'(6'h3f));
        end

        bus.next_move  = 4'd4;
        bus.next_turns = 2'd1;
        bus.move_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.move_start = 1'b0;
            chk("abort run en", 32'(bus.en_pins), 32'(6'b111101));
            chk("abort run step", 32'(bus.step_pin), 32'(exp_step(c, pq, 3)));
            if (c == 6) begin
                bus.next_move  = 4'd2;
                bus.move_start = 1'b1;
            end
        end
        bus.disable_steppers = 1'b1;
        tick();
        chk("abort en", 32'(bus.en_pins), 32'(6'h3f));
        chk("abort step", 32'(bus.step_pin), 32'd0);
        chk("abort done", 32'(bus.move_done), 32'd1);
        chk("abort ready", 32'(bus.move_ready), 32'd1);
        chk("abort flag", 32'(bus.move_aborted), 32'd1);

        bus.next_move  = 4'd14;
        bus.move_start = 1'b1;
        tick();
        bus.move_start = 1'b0;
        tick();
        chk("disabled invalid", 32'(bus.invalid_move), 32'd0);
        bus.next_move  = 4'd2;
        bus.move_start = 1'b1;
        tick();
        bus.move_start = 1'b0;
        chk("disabled reject en", 32'(bus.en_pins), 32'(6'h3f));
        chk("disabled reject done", 32'(bus.move_done), 32'd1);
        chk("abort sticky", 32'(bus.move_aborted), 32'd1);

        bus.disable_steppers = 1'b0;
        bus.move_start       = 1'b1;
        tick();
        bus.move_start = 1'b0;
        chk("reaccept abort clr", 32'(bus.move_aborted), 32'd0);
        chk("reaccept en", 32'(bus.en_pins), 32'(6'b111110));
        tick();
        tick();
        chk("pre-reset step", 32'(bus.step_pin), 32'd1);
        reset = 1'b1;
        #1;
        chk("async rst step", 32'(bus.step_pin), 32'd0);
        chk("async rst en", 32'(bus.en_pins), 32'(6'h3f));
        chk("async rst dir", 32'(bus.dir_pin), 32'd0);
        chk("async rst done", 32'(bus.move_done), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
